// File: rtl/mips_perf_pkg.sv
// Shared definitions for the MIPS performance-counter bank: register
// map offsets, CTRL bit positions and the control-register layout.
package mips_perf_pkg;

  localparam int DATA_W       = 32;
  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_FRZ_BIT = 1;

  typedef struct packed {
    logic frz;
    logic en;
  } ctrl_t;

  // The OVF register sits directly after the last counter slot.
  function automatic int ovf_ofs(input int num_cnt);
    return num_cnt;
  endfunction

  // The CTRL register sits directly after OVF.
  function automatic int ctrl_ofs(input int num_cnt);
    return num_cnt + 1;
  endfunction

endpackage

// File: rtl/mips_perf_counter.sv
// One performance-counter channel. It supports clear, preload and a gated
// increment that either wraps or saturates at all-ones. ovf_pulse is high
// in any cycle where an increment is attempted from all-ones.
module mips_perf_counter #(
  parameter int CNT_WIDTH = 32,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 ovf_pulse
);

  localparam logic [CNT_WIDTH-1:0] ALL_ONES = '1;

  logic at_max;
  logic step;

  assign at_max    = (cnt == ALL_ONES);
  // Clear and preload both take priority over an increment.
  assign step      = inc & ~clr & ~load;
  assign ovf_pulse = step & at_max;

  // Counter register: clear > preload > increment > hold.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples pre-edge values, with no dependence on block order.
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (step) begin
      if (SATURATE && at_max) begin
        cnt <= cnt;
      end else begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/mips_perf_counter_bank.sv
// Performance-counter bank for the MIPS CPU. It holds NUM_CNT event
// counters with snapshot shadows, sticky overflow flags and enable/freeze
// control. All of these are reached through a 1-cycle-latency register
// port. perf_sig exports a registered non-zero flag for each counter.
module mips_perf_counter_bank
  import mips_perf_pkg::*;
#(
  parameter int NUM_CNT      = 8,
  parameter int CNT_WIDTH    = 32,
  parameter bit SATURATE     = 1'b0,
  parameter bit CH0_IS_CYCLE = 1'b1,
  parameter int AW           = $clog2(NUM_CNT + 2)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_CNT-1:0] evt,
  input  logic               snap,
  input  logic               clr,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_addr,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_valid,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  output logic [NUM_CNT-1:0] perf_sig
);

  localparam int OVF_OFS  = ovf_ofs(NUM_CNT);
  localparam int CTRL_OFS = ctrl_ofs(NUM_CNT);

  logic [CNT_WIDTH-1:0] live   [NUM_CNT];
  logic [CNT_WIDTH-1:0] shadow [NUM_CNT];
  logic [NUM_CNT-1:0]   ovf;
  logic [NUM_CNT-1:0]   ovf_pulse;
  logic [NUM_CNT-1:0]   load;
  logic [NUM_CNT-1:0]   inc;
  logic [NUM_CNT-1:0]   ovf_w1c;
  logic                 ctrl_wr;
  logic [DATA_W-1:0]    rd_mux;
  ctrl_t                ctrl;

  // Write decode and per-channel increment qualification.
  always_comb begin
    // NOTE: every signal gets a default before any conditional assignment,
    // so no path leaves a value unassigned and no latch is inferred.
    load    = '0;
    inc     = '0;
    ovf_w1c = '0;
    ctrl_wr = wr_en && (wr_addr == AW'(CTRL_OFS));
    if (wr_en && (wr_addr == AW'(OVF_OFS))) begin
      ovf_w1c = wr_data[NUM_CNT-1:0];
    end
    for (int i = 0; i < NUM_CNT; i++) begin
      load[i] = wr_en && (wr_addr == AW'(i));
      inc[i]  = ctrl.en & ~ctrl.frz & (((i == 0) && CH0_IS_CYCLE) ? 1'b1 : evt[i]);
    end
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : gen_ch
    mips_perf_counter #(
      .CNT_WIDTH (CNT_WIDTH),
      .SATURATE  (SATURATE)
    ) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .load      (load[g]),
      .load_val  (wr_data[CNT_WIDTH-1:0]),
      .inc       (inc[g]),
      .cnt       (live[g]),
      .ovf_pulse (ovf_pulse[g])
    );
  end

  // Sticky overflow flags: a new overflow wins over a same-cycle W1C.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= '0;
    end else if (clr) begin
      ovf <= '0;
    end else begin
      ovf <= (ovf & ~ovf_w1c) | ovf_pulse;
    end
  end

  // Control register: counting is enabled and not frozen out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl.en  <= 1'b1;
      ctrl.frz <= 1'b0;
    end else if (ctrl_wr) begin
      ctrl.en  <= wr_data[CTRL_EN_BIT];
      ctrl.frz <= wr_data[CTRL_FRZ_BIT];
    end
  end

  // Snapshot shadows capture the live values from before this edge's update.
  always_ff @(posedge clk) begin
    // NOTE: the shadow array is reset deliberately, because software can
    // read it before the first snapshot and must see zero there.
    if (!rst_n) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        shadow[i] <= '0;
      end
    end else if (snap) begin
      shadow <= live;
    end
  end

  // Read mux. Unmapped addresses return zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_addr == AW'(i)) begin
        rd_mux = DATA_W'(shadow[i]);
      end
    end
    if (rd_addr == AW'(OVF_OFS)) begin
      rd_mux = DATA_W'(ovf);
    end
    if (rd_addr == AW'(CTRL_OFS)) begin
      rd_mux[CTRL_EN_BIT]  = ctrl.en;
      rd_mux[CTRL_FRZ_BIT] = ctrl.frz;
    end
  end

  // Registered read port. rd_data holds its value between reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_mux;
      end
    end
  end

  // Registered non-zero flag per counter, which keeps the counters
  // observable at the pins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_sig <= '0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        perf_sig[i] <= |live[i];
      end
    end
  end

endmodule

// File: tb/tb_mips_perf_counter_bank.sv
// Scoreboard bench for mips_perf_counter_bank. Two 4-bit, 8-channel
// instances (wrap and saturate) share one stimulus stream. A behavioural
// model pushes the expected outputs of each cycle into a queue, and a
// monitor pops and compares them on the falling edge.
module tb_mips_perf_counter_bank;

  localparam int N   = 8;
  localparam int AW  = 4;
  localparam int MAXV = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  evt;
  logic          snap, clr, rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [31:0]   wr_data;
  logic [31:0]   rd_data_w, rd_data_s;
  logic          rd_valid_w, rd_valid_s;
  logic [N-1:0]  perf_w, perf_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_perf_counter_bank #(.NUM_CNT(N), .CNT_WIDTH(4), .SATURATE(1'b0), .CH0_IS_CYCLE(1'b1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .evt(evt), .snap(snap), .clr(clr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_w), .rd_valid(rd_valid_w),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .perf_sig(perf_w));

  mips_perf_counter_bank #(.NUM_CNT(N), .CNT_WIDTH(4), .SATURATE(1'b1), .CH0_IS_CYCLE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .evt(evt), .snap(snap), .clr(clr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_s), .rd_valid(rd_valid_s),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .perf_sig(perf_s));

  typedef struct {
    bit         valid;
    int         data;
    bit [N-1:0] perf;
  } exp_t;

  exp_t q_w[$];
  exp_t q_s[$];

  // Reference state: index 0 = wrap instance, index 1 = saturate instance.
  int         m_live   [2][N];
  int         m_shadow [2][N];
  bit [N-1:0] m_ovf    [2];
  bit         m_en     [2];
  bit         m_frz    [2];
  int         m_rd_data[2];
  bit         m_rd_vld [2];
  bit [N-1:0] m_perf   [2];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int reg_read(input int m, input int a);
    if (a < N)  return m_shadow[m][a];
    if (a == N) return int'(m_ovf[m]);
    if (a == N + 1) return int'(m_en[m]) + 2 * int'(m_frz[m]);
    return 0;
  endfunction

  // Advance the model by one clock edge and queue the expected outputs.
  task automatic model_step(input int m);
    int   pre[N];
    bit   pulse[N];
    exp_t e;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_live[m][i]   = 0;
        m_shadow[m][i] = 0;
      end
      m_ovf[m] = '0; m_en[m] = 1'b1; m_frz[m] = 1'b0;
      m_rd_data[m] = 0; m_rd_vld[m] = 1'b0; m_perf[m] = '0;
    end else begin
      pre = m_live[m];
      for (int i = 0; i < N; i++) m_perf[m][i] = (pre[i] != 0);
      m_rd_vld[m] = rd_en;
      if (rd_en) m_rd_data[m] = reg_read(m, int'(rd_addr));
      if (snap) m_shadow[m] = pre;
      for (int i = 0; i < N; i++) begin
        pulse[i] = 1'b0;
        if (clr) m_live[m][i] = 0;
        else if (wr_en && int'(wr_addr) == i) m_live[m][i] = int'(wr_data) & MAXV;
        else if (m_en[m] && !m_frz[m] && (i == 0 || evt[i])) begin
          if (pre[i] == MAXV) begin
            pulse[i] = 1'b1;
            m_live[m][i] = (m == 1) ? MAXV : 0;
          end else begin
            m_live[m][i] = pre[i] + 1;
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (clr) m_ovf[m][i] = 1'b0;
        else begin
          if (wr_en && int'(wr_addr) == N && wr_data[i]) m_ovf[m][i] = 1'b0;
          if (pulse[i]) m_ovf[m][i] = 1'b1;
        end
      end
      if (wr_en && int'(wr_addr) == N + 1) begin
        m_en[m]  = wr_data[0];
        m_frz[m] = wr_data[1];
      end
    end
    e.valid = m_rd_vld[m];
    e.data  = m_rd_data[m];
    e.perf  = m_perf[m];
    if (m == 0) q_w.push_back(e);
    else        q_s.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
  endtask

  task automatic idle();
    evt = '0; snap = 0; clr = 0; rd_en = 0; wr_en = 0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic write_reg(input int a, input logic [31:0] d);
    wr_en = 1; wr_addr = AW'(a); wr_data = d;
    step();
    wr_en = 0;
  endtask

  task automatic read_reg(input int a, output logic [31:0] dw, output logic [31:0] ds);
    rd_en = 1; rd_addr = AW'(a);
    step();
    rd_en = 0;
    dw = rd_data_w;
    ds = rd_data_s;
  endtask

  task automatic do_snap();
    snap = 1;
    step();
    snap = 0;
  endtask

  task automatic compare(input string tag, input exp_t e, input logic vld,
                         input logic [31:0] data, input logic [N-1:0] perf);
    check({tag, "_rd_valid"}, 32'(vld), 32'(e.valid));
    if (e.valid) check({tag, "_rd_data"}, data, e.data);
    check({tag, "_perf_sig"}, 32'(perf), 32'(e.perf));
  endtask

  // Monitor: compare every cycle's outputs against the queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q_w.size() > 0) begin
        e = q_w.pop_front();
        compare("wrap", e, rd_valid_w, rd_data_w, perf_w);
      end
      if (q_s.size() > 0) begin
        e = q_s.pop_front();
        compare("sat", e, rd_valid_s, rd_data_s, perf_s);
      end
    end
  end

  initial begin
    logic [31:0] dw, ds;
    idle();
    rst_n = 0;
    @(negedge clk);

    // Reset with every event line high.
    evt = '1;
    step(); step();
    check("reset_perf_w", 32'(perf_w), 0);
    check("reset_perf_s", 32'(perf_s), 0);
    evt = '0;
    rst_n = 1;
    read_reg(N + 1, dw, ds);
    check("reset_ctrl", dw, 32'h1);
    read_reg(N, dw, ds);
    check("reset_ovf", dw, 32'h0);

    // Cycle counter and event counter, followed by a freeze.
    evt[3] = 1;
    repeat (5) step();
    evt = '0;
    do_snap();
    read_reg(0, dw, ds);
    read_reg(3, dw, ds);
    check("evt3_count", dw, 32'd5);
    write_reg(N + 1, 32'h3);
    evt[3] = 1;
    repeat (10) step();
    evt = '0;
    do_snap();
    read_reg(3, dw, ds);
    check("frz_hold3", dw, 32'd5);
    read_reg(0, dw, ds);

    // Preload near all-ones, then wrap or saturate.
    write_reg(N + 1, 32'h1);
    write_reg(1, 32'hE);
    evt[1] = 1;
    repeat (3) step();
    evt = '0;
    do_snap();
    read_reg(1, dw, ds);
    check("wrap_val", dw, 32'h1);
    check("sat_val", ds, 32'hF);
    read_reg(N, dw, ds);
    check("wrap_ovf1", (dw >> 1) & 1, 1);
    check("sat_ovf1", (ds >> 1) & 1, 1);
    write_reg(N, 32'h2);
    read_reg(N, dw, ds);
    check("w1c_ovf1", (dw >> 1) & 1, 0);

    // Collisions between controls.
    evt[2] = 1; step(); step();
    clr = 1; step(); clr = 0;
    evt = '0;
    do_snap();
    read_reg(2, dw, ds);
    check("clr_beats_evt", dw, 0);
    evt[2] = 1; repeat (3) step(); evt = '0;
    snap = 1; clr = 1; step(); snap = 0; clr = 0;
    read_reg(2, dw, ds);
    check("snap_pre_clr", dw, 32'd3);
    evt[4] = 1; write_reg(4, 32'h7); evt = '0;
    do_snap();
    read_reg(4, dw, ds);
    check("load_beats_evt", dw, 32'd7);
    write_reg(5, 32'hF);
    evt[5] = 1; write_reg(N, 32'h20); evt = '0;
    read_reg(N, dw, ds);
    check("ovf_beats_w1c_w", (dw >> 5) & 1, 1);
    check("ovf_beats_w1c_s", (ds >> 5) & 1, 1);

    // Back-to-back reads, an out-of-range read, and a reset during a read.
    for (int a = 0; a < 4; a++) begin
      rd_en = 1; rd_addr = AW'(a);
      step();
      check("burst_valid", 32'(rd_valid_w), 1);
    end
    rd_addr = AW'(N + 5);
    step();
    check("oor_read", rd_data_w, 0);
    rst_n = 0;
    step();
    check("rst_drops_valid", 32'(rd_valid_w), 0);
    rd_en = 0; rst_n = 1;
    step();

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      rst_n   = ($urandom_range(0, 99) != 0);
      clr     = ($urandom_range(0, 31) == 0);
      snap    = ($urandom_range(0, 7) == 0);
      evt     = N'($urandom);
      rd_en   = $urandom_range(0, 1) == 1;
      rd_addr = AW'($urandom_range(0, 15));
      wr_en   = ($urandom_range(0, 5) == 0);
      wr_addr = AW'($urandom_range(0, 15));
      wr_data = $urandom;
      if (int'(wr_addr) == N + 1) wr_data[0] = ($urandom_range(0, 3) != 0);
      step();
    end
    idle();
    rst_n = 1;
    step();
    @(negedge clk);
    @(negedge clk);
    check("queue_drained_w", q_w.size(), 0);
    check("queue_drained_s", q_s.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
